// File: rtl/mul_pkg.sv
// Shared definitions for the sequential multiplier: opcode values seen on
// the Signal bus and the controller state encoding.
package mul_pkg;

    localparam logic [5:0] MULTU = 6'b011001;
    localparam logic [5:0] MULT  = 6'b011000;
    localparam logic [5:0] OUT   = 6'b111111;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/seq_multiplier_if.sv
// Command/result bundle of the sequential multiplier. The master side issues
// commands and operands; the slave side (the multiplier) returns status and
// the registered product.
interface seq_multiplier_if #(
    parameter int WIDTH = 32
);

    logic [WIDTH-1:0]   dataA;
    logic [WIDTH-1:0]   dataB;
    logic [5:0]         Signal;
    logic               start;
    logic               busy;
    logic               done;
    logic [2*WIDTH-1:0] dataOut;

    modport master (
        output dataA, dataB, Signal, start,
        input  busy, done, dataOut
    );

    modport slave (
        input  dataA, dataB, Signal, start,
        output busy, done, dataOut
    );

endinterface

// File: rtl/cond_negate.sv
// Conditional two's-complement negation: passes value through unchanged when
// neg is low, otherwise returns -value in the same width.
module cond_negate #(
    parameter int WIDTH = 32
) (
    input  logic             neg,
    input  logic [WIDTH-1:0] value,
    output logic [WIDTH-1:0] result
);

    // Invert-and-increment only when negation is requested.
    always_comb begin
        result = neg ? WIDTH'(~value + 1'b1) : value;
    end

endmodule

// File: rtl/seq_multiplier.sv
// Sequential shift-and-add multiplier, one multiplier bit per clock.
// A command is taken only while idle; the product appears WIDTH+1 cycles
// after the start cycle together with a one-cycle done pulse.
// Build option: define MULT_SIGNED_EN to enable the signed MULT opcode;
// without it MULT is ignored like any other unknown opcode.
module seq_multiplier
    import mul_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    seq_multiplier_if.slave  bus
);

    localparam int CW = $clog2(WIDTH);

    state_t             state;
    state_t             nextState;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] accNext;
    logic [2*WIDTH-1:0] mcand;
    logic [2*WIDTH-1:0] product;
    logic [WIDTH-1:0]   mplier;
    logic [WIDTH-1:0]   loadA;
    logic [WIDTH-1:0]   loadB;
    logic [CW-1:0]      count;
    logic               acceptMul;
    logic               acceptOut;
    logic               lastStep;
    logic               negProduct;

`ifdef MULT_SIGNED_EN
    logic               sign;
    logic [WIDTH-1:0]   magA;
    logic [WIDTH-1:0]   magB;

    // Magnitudes of the operands; the most-negative value maps to its
    // unsigned magnitude, which still fits in WIDTH bits.
    cond_negate #(.WIDTH(WIDTH)) uNegA (
        .neg    (bus.dataA[WIDTH-1]),
        .value  (bus.dataA),
        .result (magA)
    );

    cond_negate #(.WIDTH(WIDTH)) uNegB (
        .neg    (bus.dataB[WIDTH-1]),
        .value  (bus.dataB),
        .result (magB)
    );

    assign loadA      = (bus.Signal == MULT) ? magA : bus.dataA;
    assign loadB      = (bus.Signal == MULT) ? magB : bus.dataB;
    assign negProduct = sign;
`else
    assign loadA      = bus.dataA;
    assign loadB      = bus.dataB;
    assign negProduct = 1'b0;
`endif

    // Partial-product sum including the current multiplier bit, so the
    // final step's contribution is captured on the same edge as dataOut.
    assign accNext = acc + (mplier[0] ? mcand : '0);

    // Sign correction of the finished product; with the signed opcode
    // disabled the control input is tied low and this reduces to wires.
    cond_negate #(.WIDTH(2*WIDTH)) uNegProd (
        .neg    (negProduct),
        .value  (accNext),
        .result (product)
    );

    assign bus.busy = (state == RUN);

    // Controller state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    // Command decode in IDLE and end-of-run detection in RUN.
    always_comb begin
        nextState = state;
        acceptMul = 1'b0;
        acceptOut = 1'b0;
        lastStep  = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    if (bus.Signal == MULTU) begin
                        acceptMul = 1'b1;
                        nextState = RUN;
                    end
`ifdef MULT_SIGNED_EN
                    else if (bus.Signal == MULT) begin
                        acceptMul = 1'b1;
                        nextState = RUN;
                    end
`endif
                    else if (bus.Signal == OUT) begin
                        acceptOut = 1'b1;
                    end
                end
            end
            RUN: begin
                if (count == CW'(WIDTH - 1)) begin
                    lastStep  = 1'b1;
                    nextState = IDLE;
                end
            end
            default: nextState = IDLE;
        endcase
    end

    // Datapath: operand load, shift-and-add steps, result and done pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc         <= '0;
            mcand       <= '0;
            mplier      <= '0;
            count       <= '0;
            bus.dataOut <= '0;
            bus.done    <= 1'b0;
`ifdef MULT_SIGNED_EN
            sign        <= 1'b0;
`endif
        end else begin
            bus.done <= 1'b0;
            if (acceptMul) begin
                acc    <= '0;
                mcand  <= {{WIDTH{1'b0}}, loadA};
                mplier <= loadB;
                count  <= '0;
`ifdef MULT_SIGNED_EN
                sign   <= (bus.Signal == MULT) &&
                          (bus.dataA[WIDTH-1] ^ bus.dataB[WIDTH-1]);
`endif
            end else if (state == RUN) begin
                acc    <= accNext;
                mcand  <= mcand << 1;
                mplier <= mplier >> 1;
                count  <= count + 1'b1;
                if (lastStep) begin
                    bus.dataOut <= product;
                    bus.done    <= 1'b1;
                end
            end else if (acceptOut) begin
                bus.dataOut <= '0;
            end
        end
    end

endmodule

// File: doc/seq_multiplier.md
SEQ_MULTIPLIER -- requirements
Module: seq_multiplier

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, giving the operand width in bits (legal range 4..64).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock, rising-edge active.
REQ-003 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-004 The block SHALL have port dataA, input, WIDTH bits: multiplicand, sampled when a command is accepted.
REQ-005 The block SHALL have port dataB, input, WIDTH bits: multiplier, sampled when a command is accepted.
REQ-006 The block SHALL have port Signal, input, 6 bits: opcode (MULTU=6'b011001, MULT=6'b011000, OUT=6'b111111).
REQ-007 The block SHALL have port start, input, 1 bit: command strobe, qualifies Signal.
REQ-008 The block SHALL have port busy, output, 1 bit: an operation is in progress.
REQ-009 The block SHALL have port done, output, 1 bit: one-cycle pulse marking dataOut as updated with a new product.
REQ-010 The block SHALL have port dataOut, output, 2*WIDTH bits: registered product.

Function
REQ-011 The FSM SHALL have states IDLE and RUN; commands SHALL be accepted only in IDLE with start=1.
REQ-012 When accepted, MULTU SHALL load the unsigned operands, clear the accumulator and the bit counter, and go to RUN.
REQ-013 When accepted, MULT SHALL load |dataA| and |dataB| as WIDTH-bit magnitudes, record sign = dataA[MSB] XOR dataB[MSB], and go to RUN.
REQ-014 Each RUN cycle SHALL add the shifted multiplicand to the 2*WIDTH-bit accumulator if the multiplier LSB is 1, then shift the multiplicand left by 1 and the multiplier right by 1.
REQ-015 RUN SHALL last exactly WIDTH cycles; busy=1 throughout RUN and 0 otherwise.
REQ-016 On the final RUN edge, the block SHALL load dataOut with the accumulator (two's-complement negated if MULT and sign=1), set done=1 for exactly one cycle, and return to IDLE.
REQ-017 Latency: with start in cycle 0, done=1 and the new dataOut SHALL be present in cycle WIDTH+1.
REQ-018 start during RUN SHALL be ignored, with no queuing.
REQ-019 start during the done cycle SHALL be accepted, giving back-to-back operation with no gap.
REQ-020 An accepted OUT command SHALL clear dataOut to 0 in the next cycle, stay in IDLE, and not assert done.
REQ-021 An unrecognised opcode with start=1 SHALL be ignored: no state change, no output change.
REQ-022 dataOut SHALL hold its value between completions.
REQ-023 Accumulation SHALL be 2*WIDTH bits wide with no overflow possible; MULT of the most-negative value by itself SHALL yield +2^(2*WIDTH-2).

Reset
REQ-024 Reset SHALL force state=IDLE, busy=0, done=0, dataOut=0, accumulator=0, counter=0, sign=0, asynchronously and at any time.
REQ-025 Reset asserted mid-RUN SHALL abort the operation with no done pulse; the first start after reset release SHALL be accepted normally.

Configuration
REQ-026 With macro MULT_SIGNED_EN defined, MULT SHALL be decoded as specified above.
REQ-027 Without MULT_SIGNED_EN, MULT SHALL be treated as an unrecognised opcode (per REQ-021), and the sign and magnitude logic SHALL be absent.

Structure
REQ-028 Package mul_pkg SHALL hold the opcode constants (MULTU, MULT, OUT) and the FSM state enumeration.
REQ-029 Sub-module cond_negate (parameterised width, conditional two's-complement negation) SHALL be used for the operand magnitudes and the product sign correction.

Verification (WIDTH=32)
REQ-030 The bench SHALL check: reset, then MULTU 0xFFFFFFFF x 0xFFFFFFFF -> done in cycle 33, dataOut=0xFFFFFFFE00000001, busy high in cycles 1..32.
REQ-031 The bench SHALL check, with MULT_SIGNED_EN defined: MULT -3 x 5 -> 0xFFFFFFFFFFFFFFF1; MULT 0x80000000 x 0x80000000 -> 0x4000000000000000; MULT -1 x -1 -> 1.
REQ-032 The bench SHALL check, without MULT_SIGNED_EN: MULT 7 x 6 with start -> busy stays 0, no done, dataOut unchanged.
REQ-033 The bench SHALL check: MULTU 3 x 4, then start pulsed mid-RUN with MULTU 9 x 9 -> result 12 only; a new start in the done cycle -> second product 81 after a further 33 cycles.
REQ-034 The bench SHALL check: reset asserted at RUN cycle 10 -> outputs 0 immediately, no done; then MULTU 2 x 3 -> 6; then OUT -> dataOut=0, done stays 0.
